univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised successor to the team's 4-bit enable register.
- Holds a WIDTH-bit value with synchronous reset and clock enable.
- Adds mode-selected parallel load, logical and arithmetic shifts, rotates, and serial in/out.
- Adds a multi-cycle burst engine that applies a shift/rotate N times, with a busy/done handshake.
- Sits in the datapath as a general staging/shift register for serial links and bit-manipulation units.

Parameters:
WIDTH, 4, data width in bits (>=2)
CNT_W, 3, width of burst amount; max burst = 2**CNT_W-1 steps

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  clock enable; 0 freezes all state (including the burst counter)
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
ser_lsb  input  1  bit shifted into bit 0 on SHL
ser_msb  input  1  bit shifted into bit WIDTH-1 on SHR
start  input  1  request burst of amount steps (sampled in IDLE with en=1)
amount  input  CNT_W  burst step count
q  output  WIDTH  register contents
ser_out  output  1  registered copy of the last bit shifted or rotated out
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising clk edge.
- Reset (rst=1 at edge): q=0, ser_out=0, busy=0, done=0, state=IDLE, count=0. Reset beats en and start.
- Reset mid-burst aborts the burst: state=IDLE, q=0, and done is not pulsed.
- Modes (one step):
  - 000 HOLD
  - 001 LOAD: q<=d
  - 010 SHL: q<={q[W-2:0],ser_lsb}, ser_out<=q[W-1]
  - 011 SHR: q<={ser_msb,q[W-1:1]}, ser_out<=q[0]
  - 100 ROL: ser_out<=q[W-1]
  - 101 ROR: ser_out<=q[0]
  - 110 ASR: msb replicated, ser_out<=q[0]
  - 111 reserved: treated as HOLD
- ser_out changes only on shift/rotate steps.
- FSM states: IDLE, BURST.
- IDLE, en=1, start=0: apply the mode once. Latency 1 cycle (q valid on the edge after inputs).
- IDLE, en=1, start=1:
  - Latch mode and amount.
  - If amount==0 or the latched mode is HOLD/LOAD/reserved: perform one step now (a HOLD step for amount==0), pulse done on the next cycle, and stay in IDLE.
  - Otherwise: perform step 1 on this edge. If amount==1, pulse done now; else go to BURST with busy=1 and count=amount-1.
- BURST, en=1:
  - Apply the latched mode each edge and decrement count.
  - On the edge where count reaches 0: state=IDLE, busy=0, done=1 for exactly that cycle.
  - q then holds the value after amount steps.
- BURST, en=0: stall. q, count, and busy are held. done stays 0.
- While busy, the mode, d, start, and amount inputs are ignored. A start while busy is dropped, not queued.
- A new start is accepted in the cycle done is high: the FSM is IDLE and back-to-back bursts are legal.
- Burst of amount steps: busy is high for amount-1 cycles and done pulses on the amount-th enabled edge.
- Serial inputs are sampled live on every burst step, not latched at start.
- en=0 in IDLE: nothing changes. done falls to 0 on the next edge regardless of en.

Decomposition:
- Package usr_pkg holds:
  - the mode enum (HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, RSVD);
  - the state enum (IDLE, BURST);
  - a function step_f(q, mode, ser_lsb, ser_msb) that returns the next q and the out bit.
- One sub-module is natural: usr_step, purely combinational, wrapping step_f. It is shared by single-step and burst paths so both use identical shift semantics.
- The top level contains the FSM, counter, and registers.

Test Plan:
1. Reset and load, WIDTH=4: rst=1 for 2 cycles -> q=0000, busy=0, done=0. Then en=1, mode=LOAD, d=1010 -> q=1010 one cycle later.
2. Single steps from q=1010:
   - SHL ser_lsb=1 -> 0101, ser_out=1
   - SHR ser_msb=0 -> 0010, ser_out=1
   - ASR on 1000 -> 1100
   - ROR on 0001 -> 1000
3. Enable gating: q=1100, en=0 with mode=LOAD, d=0011 for 3 cycles -> q stays 1100. Set en=1 -> q=0011.
4. Burst: q=1001, start=1, mode=ROL, amount=3 -> q=0011, 0110, 1100 on successive edges. busy high for 2 cycles. done high only with q=1100.
5. Burst stall and ignore: during a 5-step SHR burst, drop en for 2 cycles mid-burst and pulse start with amount=1 -> q and busy frozen, the extra start is dropped, and done fires after exactly 5 enabled steps.
6. Reset mid-burst and edge cases:
   - ROL amount=7 with rst asserted on step 3 -> q=0000, busy=0, no done.
   - start with amount=0 -> q unchanged, done pulse one cycle later.
   - Back-to-back start on the done cycle is accepted.

Source files
------------

// File: rtl/usr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usr_pkg : shared types and the single-step shift/rotate function
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package usr_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    word_t q;
    logic  out_bit;
    logic  shifted;
  } step_t;

  // Operates on a w-bit value held in the low bits of a MAX_W word.
  // LOAD is not handled here (no data operand); it returns q unchanged.
  function automatic step_t step_f(input word_t q, input mode_e mode,
                                   input logic ser_lsb, input logic ser_msb,
                                   input int unsigned w);
    word_t mask;
    word_t top;
    word_t shl;
    word_t shr;
    logic  msb;
    logic  lsb;
    step_t r;
    mask = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    top  = word_t'(1) << (w - 1);
    msb  = |(q & top);
    lsb  = q[0];
    shl  = (q << 1) & mask;
    shr  = q >> 1;
    r.q       = q;
    r.out_bit = 1'b0;
    r.shifted = 1'b0;
    case (mode)
      MODE_SHL: begin r.q = shl | word_t'(ser_lsb);       r.out_bit = msb; r.shifted = 1'b1; end
      MODE_SHR: begin r.q = shr | (ser_msb ? top : '0);   r.out_bit = lsb; r.shifted = 1'b1; end
      MODE_ROL: begin r.q = shl | word_t'(msb);           r.out_bit = msb; r.shifted = 1'b1; end
      MODE_ROR: begin r.q = shr | (lsb ? top : '0);       r.out_bit = lsb; r.shifted = 1'b1; end
      MODE_ASR: begin r.q = shr | (msb ? top : '0);       r.out_bit = lsb; r.shifted = 1'b1; end
      default:  ;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// univ_shift_reg_if : control/data bundle for the universal shift register
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
interface univ_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_lsb;
  logic             ser_msb;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, ser_lsb, ser_msb, start, amount,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  en, mode, d, ser_lsb, ser_msb, start, amount,
    output q, ser_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/usr_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usr_step : combinational single step (load/shift/rotate) of a WIDTH-bit word
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_ser_lsb,
  input  logic             i_ser_msb,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_out_bit,
  output logic             o_shifted
);

  word_t w_q;
  step_t w_res;

  assign w_q       = word_t'(i_q);
  assign w_res     = step_f(w_q, i_mode, i_ser_lsb, i_ser_msb, WIDTH);
  assign o_q_next  = (i_mode == MODE_LOAD) ? i_d : w_res.q[WIDTH-1:0];
  assign o_out_bit = w_res.out_bit;
  assign o_shifted = w_res.shifted;

  // Upper bits of the wide result are always zero for WIDTH < MAX_W.
  generate
    if (WIDTH < MAX_W) begin : g_pad
      logic unused_hi;
      assign unused_hi = |w_res.q[MAX_W-1:WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// univ_shift_reg : universal shift register with multi-step burst engine
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  univ_shift_reg_if.slave        bus
);

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  mode_e            mode_q,    mode_d;
  logic [WIDTH-1:0] q_q,       q_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q,    done_d;

  mode_e            w_in_mode;
  mode_e            w_step_mode;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_out;
  logic             w_step_shifted;
  logic             w_one_shot;

  assign w_in_mode = mode_e'(bus.mode);

  // A zero-length burst request still occupies one edge, as a HOLD.
  always_comb begin
    w_step_mode = w_in_mode;
    if (state_q == ST_BURST)
      w_step_mode = mode_q;
    else if (bus.start && (bus.amount == '0))
      w_step_mode = MODE_HOLD;
  end

  assign w_one_shot = (bus.amount == '0) || (bus.amount == CNT_W'(1)) ||
                      (w_in_mode == MODE_HOLD) || (w_in_mode == MODE_LOAD) ||
                      (w_in_mode == MODE_RSVD);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .i_q       (q_q),
    .i_mode    (w_step_mode),
    .i_d       (bus.d),
    .i_ser_lsb (bus.ser_lsb),
    .i_ser_msb (bus.ser_msb),
    .o_q_next  (w_step_q),
    .o_out_bit (w_step_out),
    .o_shifted (w_step_shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      mode_q    <= MODE_HOLD;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mode_d    = mode_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    if (bus.en) begin
      q_d = w_step_q;
      if (w_step_shifted)
        ser_out_d = w_step_out;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mode_d = w_in_mode;
            if (w_one_shot) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_BURST;
              count_d = bus.amount - CNT_W'(1);
            end
          end
        end
        ST_BURST: begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.q       = q_q;
    bus.ser_out = ser_out_q;
    bus.busy    = (state_q == ST_BURST);
    bus.done    = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_univ_shift_reg : scoreboard bench for univ_shift_reg (WIDTH=4, CNT_W=3)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = 3;

  localparam logic [2:0] C_HOLD = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_SHL  = 3'd2;
  localparam logic [2:0] C_SHR  = 3'd3;
  localparam logic [2:0] C_ROL  = 3'd4;
  localparam logic [2:0] C_ROR  = 3'd5;
  localparam logic [2:0] C_ASR  = 3'd6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         so;
    logic         busy;
    logic         done;
  } obs_t;

  obs_t exp_q[$];

  logic [W-1:0]  m_q;
  logic          m_so;
  logic          m_busy;
  logic          m_done;
  logic [CW-1:0] m_cnt;
  logic [2:0]    m_mode;
  logic [W-1:0]  q_hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_apply(input logic [2:0] op);
    logic [W-1:0] o;
    o = m_q;
    case (op)
      C_LOAD: m_q = bus_if.d;
      C_SHL:  begin m_q = {o[W-2:0], bus_if.ser_lsb}; m_so = o[W-1]; end
      C_SHR:  begin m_q = {bus_if.ser_msb, o[W-1:1]}; m_so = o[0];   end
      C_ROL:  begin m_q = {o[W-2:0], o[W-1]};         m_so = o[W-1]; end
      C_ROR:  begin m_q = {o[0], o[W-1:1]};           m_so = o[0];   end
      C_ASR:  begin m_q = {o[W-1], o[W-1:1]};         m_so = o[0];   end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (rst) begin
      m_q = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = '0; m_mode = C_HOLD;
    end else begin
      if (bus_if.en) begin
        if (!m_busy) begin
          if (bus_if.start) begin
            if (bus_if.amount == 3'd0) model_apply(C_HOLD);
            else                       model_apply(bus_if.mode);
            if (bus_if.amount == 3'd0 || bus_if.amount == 3'd1 ||
                bus_if.mode inside {3'd0, 3'd1, 3'd7}) begin
              nd = 1'b1;
            end else begin
              m_busy = 1'b1;
              m_cnt  = bus_if.amount - 3'd1;
              m_mode = bus_if.mode;
            end
          end else begin
            model_apply(bus_if.mode);
          end
        end else begin
          model_apply(m_mode);
          m_cnt = m_cnt - 3'd1;
          if (m_cnt == 3'd0) begin
            m_busy = 1'b0;
            nd     = 1'b1;
          end
        end
      end
      m_done = nd;
    end
  endtask

  task automatic tick();
    obs_t e;
    model_edge();
    exp_q.push_back('{m_q, m_so, m_busy, m_done});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_q",       32'(bus_if.q),       32'(e.q));
    check_eq("sb_ser_out", 32'(bus_if.ser_out), 32'(e.so));
    check_eq("sb_busy",    32'(bus_if.busy),    32'(e.busy));
    check_eq("sb_done",    32'(bus_if.done),    32'(e.done));
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                       input logic s, input logic [CW-1:0] a);
    bus_if.en     = e;
    bus_if.mode   = m;
    bus_if.d      = dd;
    bus_if.start  = s;
    bus_if.amount = a;
  endtask

  task automatic load(input logic [W-1:0] v);
    drive(1'b1, C_LOAD, v, 1'b0, 3'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus_if.ser_lsb = 1'b0;
    bus_if.ser_msb = 1'b0;
    drive(1'b0, C_HOLD, 4'h0, 1'b0, 3'd0);
    m_q = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = '0; m_mode = C_HOLD;

    // Reset and load
    tick(); tick();
    check_eq("rst_q",    32'(bus_if.q),    32'h0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'h0);
    check_eq("rst_done", 32'(bus_if.done), 32'h0);
    rst = 1'b0;
    load(4'b1010);
    check_eq("load_q", 32'(bus_if.q), 32'b1010);

    // Single steps
    bus_if.ser_lsb = 1'b1;
    drive(1'b1, C_SHL, 4'h0, 1'b0, 3'd0); tick();
    check_eq("shl_q",  32'(bus_if.q),       32'b0101);
    check_eq("shl_so", 32'(bus_if.ser_out), 32'h1);
    bus_if.ser_msb = 1'b0;
    drive(1'b1, C_SHR, 4'h0, 1'b0, 3'd0); tick();
    check_eq("shr_q",  32'(bus_if.q),       32'b0010);
    check_eq("shr_so", 32'(bus_if.ser_out), 32'h1);
    load(4'b1000);
    drive(1'b1, C_ASR, 4'h0, 1'b0, 3'd0); tick();
    check_eq("asr_q", 32'(bus_if.q), 32'b1100);
    load(4'b0001);
    drive(1'b1, C_ROR, 4'h0, 1'b0, 3'd0); tick();
    check_eq("ror_q", 32'(bus_if.q), 32'b1000);

    // Enable gating
    load(4'b1100);
    drive(1'b0, C_LOAD, 4'b0011, 1'b0, 3'd0);
    repeat (3) tick();
    check_eq("gate_hold_q", 32'(bus_if.q), 32'b1100);
    bus_if.en = 1'b1; tick();
    check_eq("gate_load_q", 32'(bus_if.q), 32'b0011);

    // ROL burst of 3
    load(4'b1001);
    drive(1'b1, C_ROL, 4'h0, 1'b1, 3'd3); tick();
    check_eq("rol_b1_q",    32'(bus_if.q),    32'b0011);
    check_eq("rol_b1_busy", 32'(bus_if.busy), 32'h1);
    drive(1'b1, C_HOLD, 4'h0, 1'b0, 3'd0); tick();
    check_eq("rol_b2_q",    32'(bus_if.q),    32'b0110);
    check_eq("rol_b2_done", 32'(bus_if.done), 32'h0);
    tick();
    check_eq("rol_b3_q",    32'(bus_if.q),    32'b1100);
    check_eq("rol_b3_done", 32'(bus_if.done), 32'h1);
    check_eq("rol_b3_busy", 32'(bus_if.busy), 32'h0);
    tick();
    check_eq("rol_done_fall", 32'(bus_if.done), 32'h0);

    // SHR burst of 5 with stall and dropped start
    load(4'b1011);
    bus_if.ser_msb = 1'($urandom);
    drive(1'b1, C_SHR, 4'h0, 1'b1, 3'd5); tick();
    bus_if.ser_msb = 1'($urandom);
    drive(1'b1, C_LOAD, 4'hF, 1'b1, 3'd1); tick();
    check_eq("stall_busy_pre", 32'(bus_if.busy), 32'h1);
    q_hold = bus_if.q;
    drive(1'b0, C_LOAD, 4'hF, 1'b1, 3'd1);
    tick(); tick();
    check_eq("stall_q",    32'(bus_if.q),    32'(q_hold));
    check_eq("stall_busy", 32'(bus_if.busy), 32'h1);
    check_eq("stall_done", 32'(bus_if.done), 32'h0);
    drive(1'b1, C_HOLD, 4'h0, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      bus_if.ser_msb = 1'($urandom);
      tick();
    end
    check_eq("shr5_busy4", 32'(bus_if.busy), 32'h1);
    check_eq("shr5_done4", 32'(bus_if.done), 32'h0);
    tick();
    check_eq("shr5_done5", 32'(bus_if.done), 32'h1);
    check_eq("shr5_busy5", 32'(bus_if.busy), 32'h0);

    // Reset mid-burst
    load(4'b0110);
    drive(1'b1, C_ROL, 4'h0, 1'b1, 3'd7); tick();
    drive(1'b1, C_HOLD, 4'h0, 1'b0, 3'd0); tick();
    rst = 1'b1; tick();
    check_eq("abort_q",    32'(bus_if.q),    32'h0);
    check_eq("abort_busy", 32'(bus_if.busy), 32'h0);
    rst = 1'b0; tick();
    check_eq("abort_nodone", 32'(bus_if.done), 32'h0);

    // Zero-length burst
    load(4'b0110);
    drive(1'b1, C_SHL, 4'h0, 1'b1, 3'd0); tick();
    check_eq("amt0_q",    32'(bus_if.q),    32'b0110);
    check_eq("amt0_done", 32'(bus_if.done), 32'h1);
    drive(1'b1, C_HOLD, 4'h0, 1'b0, 3'd0); tick();
    check_eq("amt0_fall", 32'(bus_if.done), 32'h0);

    // Back-to-back bursts
    drive(1'b1, C_ROR, 4'h0, 1'b1, 3'd2); tick();
    drive(1'b1, C_HOLD, 4'h0, 1'b0, 3'd0); tick();
    check_eq("b2b_done1", 32'(bus_if.done), 32'h1);
    drive(1'b1, C_ROL, 4'h0, 1'b1, 3'd2); tick();
    check_eq("b2b_busy2", 32'(bus_if.busy), 32'h1);
    drive(1'b1, C_HOLD, 4'h0, 1'b0, 3'd0); tick();
    check_eq("b2b_done2", 32'(bus_if.done), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst            = ($urandom_range(0, 39) == 0);
      bus_if.ser_lsb = 1'($urandom);
      bus_if.ser_msb = 1'($urandom);
      drive(($urandom_range(0, 4) != 0), 3'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
